// File: rtl/rd_fifo_serializer_if.sv
// rtl/rd_fifo_serializer_if.sv - DDR word in / TX FIFO byte out bundle for rd_fifo_serializer
interface rd_fifo_serializer_if #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 6
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              fifo_full;
    logic              wr_en;
    logic [7:0]        o_data;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_byte_cnt;

    modport slave (
        input  i_valid, i_data, fifo_full,
        output o_ready, wr_en, o_data, o_busy, o_done, o_byte_cnt
    );

    modport master (
        output i_valid, i_data, fifo_full,
        input  o_ready, wr_en, o_data, o_busy, o_done, o_byte_cnt
    );
endinterface

// File: rtl/rd_fifo_serializer.sv
// rtl/rd_fifo_serializer.sv - splits one DDR read word into bytes, MSB first, into the TX FIFO
module rd_fifo_serializer #(
    parameter int DATA_W = 256,
    parameter int CNT_W  = 6
) (
    input  logic                 axi_clk,
    input  logic                 rst,
    rd_fifo_serializer_if.slave  bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_CHECK_FULL = 2'd1;
    localparam logic [1:0] S_WRITE      = 2'd2;
    localparam logic [1:0] S_DONE       = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ready_q, ready_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        ready_d = ready_q;
        wr_en_d = wr_en_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    shreg_d = bus.i_data;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK_FULL;
                end
            end
            // wr_en is low in this state, so fifo_full already accounts for every earlier write
            S_CHECK_FULL: begin
                if (!bus.fifo_full) begin
                    wr_en_d = 1'b1;
                    data_d  = shreg_q[DATA_W-1 -: 8];
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en_d = 1'b0;
                shreg_d = shreg_q << 8;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK_FULL;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            ready_q <= 1'b1;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.o_data     = data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_byte_cnt = cnt_q;
endmodule

// File: tb/tb_rd_fifo_serializer.sv
// tb/tb_rd_fifo_serializer.sv - directed self-checking bench for rd_fifo_serializer
module tb_rd_fifo_serializer;
    localparam int DATA_W = 256;
    localparam int CNT_W  = 6;
    localparam int NB     = 32;

    logic axi_clk = 1'b0;
    logic rst     = 1'b0;

    rd_fifo_serializer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    rd_fifo_serializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .axi_clk (axi_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 axi_clk = ~axi_clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic [7:0] bq[$];
    int         cq[$];
    int         acc_q[$];
    int         done_q[$];
    logic       busy_prev = 1'b0;

    // cycle j is the interval following rising edge j
    initial begin
        forever begin
            @(posedge axi_clk);
            #1;
            cyc++;
            if (bus.wr_en === 1'b1) begin
                bq.push_back(bus.o_data);
                cq.push_back(cyc);
            end
            if (bus.o_done === 1'b1) done_q.push_back(cyc);
            if (bus.o_busy === 1'b1 && busy_prev !== 1'b1) acc_q.push_back(cyc);
            busy_prev = bus.o_busy;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bq.delete();
        cq.delete();
        acc_q.delete();
        done_q.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t = 0;
        while (bq.size() < n && t < budget) begin
            @(negedge axi_clk);
            t++;
        end
        chk("bytes_timeout", bq.size() >= n, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int t = 0;
        while (done_q.size() < n && t < budget) begin
            @(negedge axi_clk);
            t++;
        end
        chk("done_timeout", done_q.size(), n);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int t = 0;
        while (acc_q.size() < n && t < budget) begin
            @(negedge axi_clk);
            t++;
        end
        chk("accept_timeout", acc_q.size() >= n, 1);
    endtask

    task automatic send(input logic [255:0] w);
        int n0;
        n0 = acc_q.size();
        @(negedge axi_clk);
        bus.i_valid = 1'b1;
        bus.i_data  = w;
        wait_acc(n0 + 1, 200);
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [255:0] repack(input int base);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < NB; i++)
            if (base + i < bq.size()) r = (r << 8) | 256'(bq[base + i]);
        return r;
    endfunction

    logic [255:0] w2, w3, w4, w5, w6;
    logic [255:0] ww[3];
    int           fall_cyc;
    int           t;

    initial begin
        for (int i = 0; i < NB; i++) w2[255 - 8*i -: 8] = 8'(i + 1);
        w3 = 256'h00112233_44556677_8899AABB_CCDDEEFF_10213243_54657687_98A9BACB_DCEDFE0F;
        w4 = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4;
        w5 = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
        w6 = 256'hC0FFEE00_BADC0DE1_5EED1234_A5A55A5A_00000001_80000000_7F7F7F7F_13579BDF;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 8; k++) ww[j][32*k +: 32] = $urandom;

        // reset held with a word offered: nothing may be captured
        rst           = 1'b0;
        bus.i_valid   = 1'b1;
        bus.i_data    = w2;
        bus.fifo_full = 1'b0;
        repeat (3) begin
            @(negedge axi_clk);
            chk("rst_ready", bus.o_ready, 1);
            chk("rst_wr_en", bus.wr_en, 0);
            chk("rst_busy", bus.o_busy, 0);
            chk("rst_done", bus.o_done, 0);
            chk("rst_cnt", bus.o_byte_cnt, 0);
            chk("rst_data", bus.o_data, 0);
        end
        chk("rst_nocap", acc_q.size(), 0);
        clr();
        rst = 1'b1;
        @(negedge axi_clk);
        chk("cap_busy", bus.o_busy, 1);
        chk("cap_ready", bus.o_ready, 0);
        bus.i_valid = 1'b0;

        // single word, FIFO never full: cadence and byte order
        wait_done(1, 200);
        chk("t2_count", bq.size(), NB);
        for (int i = 0; i < NB && i < bq.size(); i++) begin
            chk("t2_byte", bq[i], i + 1);
            chk("t2_wr_cycle", cq[i], acc_q[0] + 1 + 2*i);
        end
        chk("t2_done_cycle", done_q[0], acc_q[0] + 64);
        chk("t2_cnt_sat", bus.o_byte_cnt, NB);
        @(negedge axi_clk);
        chk("t2_done_pulse", bus.o_done, 0);
        chk("t2_ready_back", bus.o_ready, 1);
        chk("t2_busy_low", bus.o_busy, 0);
        repeat (2) @(negedge axi_clk);

        // back-pressure after the fifth byte
        clr();
        send(w3);
        wait_bytes(5, 100);
        bus.fifo_full = 1'b1;
        repeat (10) @(negedge axi_clk);
        chk("t3_stall", bq.size(), 5);
        chk("t3_stall_busy", bus.o_busy, 1);
        bus.fifo_full = 1'b0;
        fall_cyc = cyc + 1;
        wait_done(1, 200);
        chk("t3_count", bq.size(), NB);
        chk("t3_resume", (cq.size() > 5) ? cq[5] : -1, fall_cyc);
        chk("t3_word", repack(0), w3);
        repeat (2) @(negedge axi_clk);

        // second offer while busy is held off until the first word finishes
        clr();
        send(w4);
        wait_bytes(3, 100);
        bus.i_data  = '1;
        bus.i_valid = 1'b1;
        wait_acc(2, 300);
        bus.i_valid = 1'b0;
        wait_done(2, 300);
        chk("t4_count", bq.size(), 2*NB);
        chk("t4_first", repack(0), w4);
        chk("t4_second", repack(NB), {256{1'b1}});
        chk("t4_accept_cycle", (acc_q.size() > 1) ? acc_q[1] : -1, done_q[0] + 2);
        repeat (2) @(negedge axi_clk);

        // reset in the middle of a word
        clr();
        send(w5);
        wait_bytes(12, 100);
        rst = 1'b0;
        @(negedge axi_clk);
        chk("t5_wr_en", bus.wr_en, 0);
        chk("t5_cnt", bus.o_byte_cnt, 0);
        chk("t5_ready", bus.o_ready, 1);
        chk("t5_busy", bus.o_busy, 0);
        rst = 1'b1;
        repeat (5) @(negedge axi_clk);
        chk("t5_no_more", bq.size(), 12);
        chk("t5_no_done", done_q.size(), 0);
        clr();
        send(w6);
        wait_done(1, 200);
        chk("t5_count", bq.size(), NB);
        chk("t5_word", repack(0), w6);
        repeat (2) @(negedge axi_clk);

        // back-to-back random words, round trip through the repacker
        clr();
        for (int j = 0; j < 3; j++) begin
            @(negedge axi_clk);
            bus.i_data  = ww[j];
            bus.i_valid = 1'b1;
            t = 0;
            while (acc_q.size() <= j && t < 200) begin
                @(negedge axi_clk);
                t++;
            end
            chk("t6_accept", acc_q.size() > j, 1);
        end
        bus.i_valid = 1'b0;
        wait_done(3, 400);
        chk("t6_count", bq.size(), 3*NB);
        for (int j = 0; j < 3; j++) begin
            chk("t6_word", repack(NB*j), ww[j]);
            if (j > 0 && acc_q.size() > j && cq.size() > NB*j) begin
                chk("t6_gap_accept", acc_q[j], done_q[j-1] + 2);
                chk("t6_gap_wr", cq[NB*j], done_q[j-1] + 3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
